// File: rtl/div_pkg.sv
// Shared types and constants for the iterative signed divider.
// abs_w works on a 64-bit sign-extended operand so any WIDTH up to 64 can use it.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int ABS_W     = 64;

    localparam logic [DIV_WIDTH-1:0] INT_MIN  = {1'b1, {(DIV_WIDTH-1){1'b0}}};
    localparam logic [DIV_WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Magnitude of a sign-extended two's complement value; INT_MIN of a narrower
    // width maps to its unsigned magnitude in the low bits.
    function automatic logic [ABS_W-1:0] abs_w(input logic [ABS_W-1:0] v);
        return v[ABS_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on a WIDTH+1 bit partial remainder.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem_i, msb_i};
    assign diff    = shifted - {2'b00, dvs_i};

    // Non-negative trial result keeps the subtraction, otherwise restore.
    assign q_o   = ~diff[WIDTH+1];
    assign rem_o = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/div_axis_core.sv
// Iterative signed divider behind non-blocking AXI-Stream channels (no tready).
// Fixed latency: accept, WIDTH restoring steps, one fix-up cycle, one result cycle.
module div_axis_core
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_axis_dividend_tvalid,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_divisor_tvalid,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    output logic               m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

    localparam int              CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES_W    = '1;

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic               qs_q, qs_d;
    logic               rs_q, rs_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;
    logic [2*WIDTH-1:0] dout_q, dout_d;

    logic               accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   r_mag, q_fix, r_fix;

    assign accept = s_axis_dividend_tvalid && s_axis_divisor_tvalid;
    assign a_mag  = WIDTH'(abs_w(ABS_W'($signed(s_axis_dividend_tdata))));
    assign b_mag  = WIDTH'(abs_w(ABS_W'($signed(s_axis_divisor_tdata))));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .msb_i (dvd_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // dvd_q shifts out dividend bits at the top and collects quotient bits at the bottom.
    assign r_mag = rem_q[WIDTH-1:0];
    assign q_fix = qs_q ? -dvd_q : dvd_q;
    assign r_fix = rs_q ? -r_mag : r_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    rem_d   = '0;
                    qs_d    = s_axis_dividend_tdata[WIDTH-1] ^ s_axis_divisor_tdata[WIDTH-1];
                    rs_d    = s_axis_dividend_tdata[WIDTH-1];
                    dz_d    = (s_axis_divisor_tdata == '0);
                    ovf_d   = (s_axis_dividend_tdata == INT_MIN_W) &&
                              (s_axis_divisor_tdata == ONES_W);
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // A zero divisor never restores, so r_fix is the original dividend.
                if (dz_q) begin
                    dout_d = {ONES_W, r_fix};
                end else if (ovf_q) begin
                    dout_d = {INT_MIN_W, {WIDTH{1'b0}}};
                end else begin
                    dout_d = {q_fix, r_fix};
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qs_q    <= 1'b0;
            rs_q    <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            dout_q  <= dout_d;
        end
    end

    assign m_axis_dout_tvalid = (state_q == ST_DONE);
    assign m_axis_dout_tdata  = dout_q;

endmodule

// File: tb/tb_div_axis_core.sv
// Directed bench for div_axis_core: signs, special cases, latency, reset abort and hold pattern.
module tb_div_axis_core;
    import div_pkg::*;

    localparam int W      = DIV_WIDTH;
    localparam int LAT    = W + 2;
    localparam int BUDGET = 100;

    typedef logic [2*W-1:0] word_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         dvd_v, dvs_v;
    logic [W-1:0] dvd_data, dvs_data;
    logic         m_tvalid;
    word_t        m_tdata;

    int    n_checks  = 0;
    int    n_errors  = 0;
    int    pulse_cnt = 0;
    word_t exp_q[$];

    div_axis_core #(.WIDTH(W)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_axis_dividend_tvalid (dvd_v),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_divisor_tvalid  (dvs_v),
        .s_axis_divisor_tdata   (dvs_data),
        .m_axis_dout_tvalid     (m_tvalid),
        .m_axis_dout_tdata      (m_tdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_tvalid) pulse_cnt++;
    end

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        @(negedge clk);
        dvd_data = a;
        dvs_data = b;
        dvd_v    = 1'b1;
        dvs_v    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            dvd_v = 1'b0;
            dvs_v = 1'b0;
        end
    endtask

    // Called just after the accept edge; cycle 1 is the cycle following that edge.
    task automatic finish_op(input string tag, input bit hold);
        int    cyc;
        word_t got;
        cyc = -1;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge clk);
            if (m_tvalid) begin
                cyc = i;
                break;
            end
        end
        check({tag, " latency"}, word_t'(cyc), word_t'(LAT));
        got = m_tdata;
        check({tag, " data"}, got, exp_q.pop_front());
        @(posedge clk);
        #1;
        if (hold) begin
            dvd_v = 1'b0;
            dvs_v = 1'b0;
        end
        @(negedge clk);
        check({tag, " pulse width"}, word_t'(m_tvalid), word_t'(0));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input bit hold);
        exp_q.push_back({eq, er});
        launch(a, b, hold);
        finish_op(tag, hold);
    endtask

    initial begin
        rst      = 1'b1;
        dvd_v    = 1'b0;
        dvs_v    = 1'b0;
        dvd_data = '0;
        dvs_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset tvalid", word_t'(m_tvalid), word_t'(0));
        check("reset tdata", m_tdata, word_t'(0));

        run_op("100/7",   32'd100,        32'd7,          32'h0000000E, 32'h00000002, 1'b0);
        run_op("-100/7",  -32'sd100,      32'd7,          32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        run_op("100/-7",  32'd100,        -32'sd7,        32'hFFFFFFF2, 32'h00000002, 1'b0);
        run_op("-100/-7", -32'sd100,      -32'sd7,        32'h0000000E, 32'hFFFFFFFE, 1'b0);
        run_op("-7/2",    -32'sd7,        32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_op("5/0",     32'd5,          32'd0,          32'hFFFFFFFF, 32'h00000005, 1'b0);
        run_op("ovf",     INT_MIN,        ALL_ONES,       INT_MIN,      32'h00000000, 1'b0);
        run_op("min/2",   32'h80000000,   32'd2,          32'hC0000000, 32'h00000000, 1'b0);

        // Dividend alone for 10 cycles must not start anything.
        pulse_cnt = 0;
        @(negedge clk);
        dvd_data = 32'd100;
        dvs_data = 32'd7;
        dvd_v    = 1'b1;
        dvs_v    = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("one valid no result", word_t'(pulse_cnt), word_t'(0));
        exp_q.push_back({32'h0000000E, 32'h00000002});
        dvs_v = 1'b1;
        @(posedge clk);
        #1;
        dvd_v = 1'b0;
        dvs_v = 1'b0;
        finish_op("late divisor", 1'b0);

        // Reset in the middle of CALC aborts and clears the output.
        launch(32'd50, 32'd5, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulse_cnt = 0;
        repeat (45) @(posedge clk);
        #1;
        check("abort no result", word_t'(pulse_cnt), word_t'(0));
        check("abort tdata", m_tdata, word_t'(0));

        // Reset wins over a simultaneous request.
        @(negedge clk);
        rst      = 1'b1;
        dvd_data = 32'd9;
        dvs_data = 32'd3;
        dvd_v    = 1'b1;
        dvs_v    = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        dvd_v = 1'b0;
        dvs_v = 1'b0;
        pulse_cnt = 0;
        repeat (45) @(posedge clk);
        #1;
        check("reset beats accept", word_t'(pulse_cnt), word_t'(0));

        run_op("9/3 after abort", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Valids held through the result cycle, dropped on the following edge.
        pulse_cnt = 0;
        run_op("hold 7/2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b1);
        run_op("hold 8/2", 32'd8, 32'd2, 32'd4, 32'd0, 1'b1);
        repeat (45) @(posedge clk);
        #1;
        check("hold pulse count", word_t'(pulse_cnt), word_t'(2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_axis_core.md
# div_axis_core

In-house iterative signed divider that answers the dividend/divisor AXI-Stream request channels driven by the `FU_div` functional unit and returns a packed quotient/remainder on an AXI-Stream result channel. It uses Xilinx divider-generator non-blocking semantics, so no `tready` exists on any channel. It replaces the vendor `divider` IP in the core's execute stage with identical port names and result packing. Latency is fixed and independent of operand values.

## Interface
- `WIDTH`, 32, operand width in bits; result is `2*WIDTH` bits.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_dividend_tvalid`  in  1  dividend present.
- `s_axis_dividend_tdata`  in  WIDTH  dividend, two's complement.
- `s_axis_divisor_tvalid`  in  1  divisor present.
- `s_axis_divisor_tdata`  in  WIDTH  divisor, two's complement.
- `m_axis_dout_tvalid`  out  1  result valid, single-cycle pulse.
- `m_axis_dout_tdata`  out  2*WIDTH  `{quotient, remainder}`: `[2W-1:W]` is the quotient and `[W-1:0]` is the remainder.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accepts only when both `tvalid` are high in the same cycle.
  - Latches `|dividend|` and `|divisor|`, the quotient sign (`a[W-1]^b[W-1]`) and the remainder sign (`a[W-1]`).
  - Latches the flags `dz` (divisor==0) and `ovf` (dividend==`1<<(W-1)` && divisor==all-ones).
  - Clears the iteration counter and moves to CALC.
  - If only one `tvalid` is high, nothing is latched and there is no per-channel buffering.
- CALC:
  - One restoring step per cycle on a `W+1`-bit partial remainder.
  - Shift in the next dividend MSB, trial-subtract the divisor, set the quotient bit when the result is non-negative, restore otherwise.
  - Runs exactly `W` steps, counting 0..W-1, then moves to FIX.
- FIX: writes the output register as follows, then moves to DONE.
  - `dz`: quotient = all-ones, remainder = original dividend.
  - `ovf`: quotient = `1<<(W-1)`, remainder = 0.
  - Otherwise: quotient negated if the quotient sign is set, remainder negated if the remainder sign is set. Quotient truncates toward zero; remainder takes the sign of the dividend.
- DONE:
  - `m_axis_dout_tvalid`=1 for exactly one cycle, then returns to IDLE unconditionally.
  - Inputs are ignored in this cycle, even if both `tvalid` are high.
- `tvalid` on either input during CALC, FIX or DONE is ignored. No queuing, no error.
- `m_axis_dout_tdata` holds the last result until the next FIX write. The data register is not cleared on accept.

## Timing
- Accept edge E0.
- Iterations occur on edges E1..EW.
- Output register written at E(W+1).
- `m_axis_dout_tvalid` high during the cycle after E(W+1), i.e. the W+2th cycle after the accept edge (34 cycles for W=32).
- Minimum issue interval is W+3 cycles. A new accept is possible in the first IDLE cycle after DONE.
- Requester pattern (valids held until the result cycle, dropped on the following edge) is safe: DONE ignores inputs, so no re-launch occurs.
- Reset values: state=IDLE, `m_axis_dout_tvalid`=0, `m_axis_dout_tdata`=0, counter=0, flags=0.
- Reset asserted in any state aborts the operation; no `tvalid` pulse follows.
- Reset and both `tvalid` high in the same cycle: reset wins, nothing is accepted.

## Structure
- Package `div_pkg`:
  - state enum (IDLE/CALC/FIX/DONE, 2-bit)
  - default `WIDTH`
  - function `abs_w`
  - constants `INT_MIN` (`1<<(W-1)`) and `ALL_ONES`
- Sub-module `div_step`: combinational single restoring step. Inputs: partial remainder, dividend MSB, divisor. Outputs: next partial remainder and quotient bit.
- Top level holds the FSM, counter, operand/quotient shift registers, sign/special flags and the output register.

## Test plan
- 100 / 7 → tvalid pulses 34 cycles after accept, tdata = `{0x0000000E, 0x00000002}`; tvalid is high exactly 1 cycle.
- -100 / 7 → `{0xFFFFFFF2, 0xFFFFFFFE}`; 100 / -7 → `{0xFFFFFFF2, 0x00000002}`; -100 / -7 → `{0x0000000E, 0xFFFFFFFE}`.
- 5 / 0 → `{0xFFFFFFFF, 0x00000005}`; 0x80000000 / 0xFFFFFFFF → `{0x80000000, 0x00000000}`; both at the same 34-cycle latency.
- Dividend `tvalid` high with divisor `tvalid` low for 10 cycles → no accept, no tvalid. Then raise the divisor `tvalid` → accept on that edge.
- `rst` pulsed 10 cycles into CALC → no tvalid and tdata = 0. The next 9 / 3 request returns `{3, 0}` at full latency.
- Requester holds both valids through the result cycle and drops them on the following edge, across two back-to-back ops (7/2 then 8/2) → exactly two pulses, `{3,1}` then `{4,0}`, with no spurious third operation.
